pipe_stage_chain: RTL and testbench
===================================

# pipe_stage_chain

Parametrised elastic pipeline register chain with a valid/ready handshake, global stall and flush, and bubble collapsing. It is the next-generation inter-stage latch for the MIPS core. It replaces fixed-width enable-only latches between IF/ID/EX/MEM/WB and lets a hazard unit freeze or squash a stage boundary. Each instance holds up to `STAGES` words of `DATA_WIDTH` bits, keeps them in order, and sustains one transfer per cycle.

## Interface
Parameters:
- `DATA_WIDTH`, 32: payload width in bits.
- `STAGES`, 1: number of register slots, minimum 1.
- `CNT_WIDTH`, 32: width of the performance counters.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous active-high reset.
- `i_valid`  in  1  upstream word present.
- `o_ready`  out  1  chain accepts `i_data` this cycle.
- `i_data`  in  DATA_WIDTH  upstream payload.
- `o_valid`  out  1  head word present.
- `i_ready`  in  1  downstream accepts head word.
- `o_data`  out  DATA_WIDTH  head payload.
- `i_stall`  in  1  freeze all slots.
- `i_flush`  in  1  invalidate all slots.
- `o_occupancy`  out  $clog2(STAGES+1)  number of valid slots.
- `o_stall_cycles`  out  CNT_WIDTH  perf counter, see Configuration.
- `o_bubble_cycles`  out  CNT_WIDTH  perf counter, see Configuration.

## Operation
- Slot 0 is the tail and slot `STAGES-1` is the head. Each slot holds a valid bit and a data register.
- Slot k is "free" if it is not valid, or if it is moving this cycle.
  - Slot `STAGES-1` moves when `o_valid && i_ready`.
  - Slot k < `STAGES-1` moves when `valid[k]` is set and slot k+1 is free.
- `o_ready = !i_stall && !i_flush && slot0 free`. A word is accepted when `i_valid && o_ready`.
- Bubble collapsing: a valid word always advances into an empty slot ahead of it, even while the head is blocked.
- `o_valid = valid[STAGES-1] && !i_stall`. `o_data` is the head data register at all times.
- `i_stall`: no slot loads or clears. Valid bits and data are held, and `o_ready=0`, `o_valid=0`.
- `i_flush`: all valid bits clear on the next edge, the word presented in that cycle is discarded, and no transfer occurs. Flush has priority over stall.
- Data registers load only when their slot loads a new word. Empty slots keep stale data.
- `o_occupancy` is the population count of the valid bits.

## Timing
- Reset: all valid bits 0 and all data registers 0. Outputs after reset: `o_valid=0`, `o_data=0`, `o_occupancy=0`, counters 0, and `o_ready=1` (unless stalled or flushed).
- Latency through an empty, unblocked chain is `STAGES` cycles from acceptance edge to `o_valid`.
- Throughput is 1 word/cycle when `i_ready=1` and no stall.
- Full chain with `i_ready=1`: a simultaneous head pop and tail push is allowed, and `o_ready` stays 1.
- Full chain with `i_ready=0`: `o_ready=0`.
- `o_ready` depends combinationally on `i_ready`, `i_stall` and `i_flush`. No combinational path exists from `i_valid` or `i_data` to any output.
- Reset asserted mid-stream overrides stall and flush and empties the chain on that edge.

## Configuration
- `PIPE_STAGE_PERF_EN` defined:
  - `o_stall_cycles` increments each cycle with `i_stall || (valid[STAGES-1] && !i_ready)`.
  - `o_bubble_cycles` increments each cycle with `i_ready && !o_valid && !i_stall`.
  - Both counters saturate at all-ones and are cleared by `rst` only.
- Not defined: both counter outputs are tied to 0 and no counter flops are built.

## Structure
- Shared package `mips_pkg`:
  - Default `DATA_WIDTH`.
  - Control-bit index constants (REG_WRITE … JUMP_OR_B).
  - Per-boundary payload widths (IF/ID 32, ID/EX 124, EX/MEM 77, MEM/WB 71).
- Sub-module `pipe_slot`: one valid bit plus data register with load/clear controls, instantiated `STAGES` times in a generate loop. Chain control and counters live in the top.

## Test plan
Unless noted: `STAGES=3`, `DATA_WIDTH=32`, `PIPE_STAGE_PERF_EN` defined.
- Reset: hold `rst` for 2 cycles with `i_valid=1` → `o_valid=0`, `o_data=0`, `o_occupancy=0`, counters 0; `o_ready=1` after release.
- Streaming: push 0x1, 0x2, 0x3 on consecutive cycles with `i_ready=1` → 0x1 appears 3 cycles after its acceptance, then 0x2 and 0x3 on the following cycles.
- Backpressure: `i_ready=0`, push 0xA, 0xB, 0xC, 0xD → first three accepted, then `o_ready=0`, `o_occupancy=3`, and `o_stall_cycles` increments while the head is blocked. Raise `i_ready` → output order 0xA, 0xB, 0xC, then 0xD is accepted.
- Flush: `o_occupancy=2`, then `i_flush=1` with `i_valid=1` and `i_data=0x55` → next cycle `o_occupancy=0`, `o_valid=0`, and 0x55 never emerges.
- Stall: `i_stall=1` for 5 cycles with occupancy 2 → `o_valid=0`, `o_ready=0`, occupancy holds at 2, `o_stall_cycles` +5. Release → original words emerge in order.
- Bubble collapse: push 0x7, idle 2 cycles, push 0x8 with `i_ready=0` → both slots packed at the head, `o_occupancy=2`. Release → 0x7 then 0x8 on back-to-back cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline latches: default payload width,
// control-bit positions inside the ID/EX control field, and the payload
// width carried across each stage boundary.
package mips_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  // Bit positions of the decoded control signals in the control field.
  localparam int REG_WRITE  = 0;
  localparam int MEM_TO_REG = 1;
  localparam int MEM_WRITE  = 2;
  localparam int MEM_READ   = 3;
  localparam int BRANCH     = 4;
  localparam int ALU_SRC    = 5;
  localparam int REG_DST    = 6;
  localparam int JUMP_OR_B  = 7;

  // Payload widths of the four inter-stage boundaries.
  localparam int IF_ID_WIDTH  = 32;
  localparam int ID_EX_WIDTH  = 124;
  localparam int EX_MEM_WIDTH = 77;
  localparam int MEM_WB_WIDTH = 71;

endpackage

// File: rtl/pipe_slot.sv
// One register slot of the elastic chain: a valid bit plus a data word.
// Ports: clk/rst (sync, active-high), i_load writes i_data and sets valid,
//        i_clear drops valid (load wins), o_valid/o_data are the registers.
module pipe_slot
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  valid_d, valid_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    // A slot that hands its word forward and takes a new one in the same
    // cycle must stay valid, so load takes priority over clear.
    if (i_load) begin
      valid_d = 1'b1;
      data_d  = i_data;
    end else if (i_clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic in-order register chain with valid/ready handshake, global stall,
// flush and bubble collapsing. Slot 0 is the tail, slot STAGES-1 the head.
// Ports: upstream i_valid/o_ready/i_data, downstream o_valid/i_ready/o_data,
//        i_stall, i_flush, o_occupancy, o_stall_cycles, o_bubble_cycles.
// Macro PIPE_STAGE_PERF_EN builds the saturating perf counters; otherwise
// both counter outputs are constant zero.
module pipe_stage_chain
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int STAGES     = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [DATA_WIDTH-1:0]        o_data,
  input  logic                         i_stall,
  input  logic                         i_flush,
  output logic [$clog2(STAGES+1)-1:0]  o_occupancy,
  output logic [CNT_WIDTH-1:0]         o_stall_cycles,
  output logic [CNT_WIDTH-1:0]         o_bubble_cycles
);

  localparam int OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0]     valid;
  logic [STAGES-1:0]     move;
  logic [STAGES-1:0]     free;
  logic [STAGES-1:0]     load;
  logic [STAGES-1:0]     clear;
  logic [DATA_WIDTH-1:0] data    [STAGES];
  logic [DATA_WIDTH-1:0] slot_in [STAGES];
  logic                  xfer_en;
  logic [OCC_W-1:0]      occ;

  always_comb begin
    xfer_en = !i_stall && !i_flush;
    move    = '0;
    free    = '0;
    // Freedom ripples from head to tail; gating every move with xfer_en
    // also stops bubble collapsing while stalled or flushing.
    move[STAGES-1] = valid[STAGES-1] && i_ready && xfer_en;
    free[STAGES-1] = !valid[STAGES-1] || move[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) begin
      move[k] = valid[k] && free[k+1] && xfer_en;
      free[k] = !valid[k] || move[k];
    end

    o_ready    = xfer_en && free[0];
    load       = '0;
    load[0]    = i_valid && o_ready;
    slot_in[0] = i_data;
    for (int k = 1; k < STAGES; k++) begin
      load[k]    = move[k-1];
      slot_in[k] = data[k-1];
    end
    clear = move | {STAGES{i_flush}};
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_slot
    pipe_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (load[g]),
      .i_clear (clear[g]),
      .i_data  (slot_in[g]),
      .o_valid (valid[g]),
      .o_data  (data[g])
    );
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ = occ + OCC_W'(valid[k]);
    end
  end

  assign o_occupancy = occ;
  assign o_valid     = valid[STAGES-1] && !i_stall;
  assign o_data      = data[STAGES-1];

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_WIDTH-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_WIDTH-1:0] bubble_cnt_d, bubble_cnt_q;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if ((i_stall || (valid[STAGES-1] && !i_ready)) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
    if (i_ready && !o_valid && !i_stall && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_stall_cycles  = stall_cnt_q;
  assign o_bubble_cycles = bubble_cnt_q;
`else
  assign o_stall_cycles  = '0;
  assign o_bubble_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain with STAGES=3, DATA_WIDTH=32.
// Inputs change 1 time unit after the rising edge and outputs are sampled
// one further unit later, away from the edge.
module tb_pipe_stage_chain;

  localparam int DW = 32;
  localparam int ST = 3;
  localparam int CW = 32;
  localparam int OW = $clog2(ST + 1);
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_data = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [DW-1:0] o_data;
  logic          i_stall = 1'b0;
  logic          i_flush = 1'b0;
  logic [OW-1:0] o_occupancy;
  logic [CW-1:0] o_stall_cycles;
  logic [CW-1:0] o_bubble_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_stage_chain #(.DATA_WIDTH(DW), .STAGES(ST), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_data          (i_data),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_data          (o_data),
    .i_stall         (i_stall),
    .i_flush         (i_flush),
    .o_occupancy     (o_occupancy),
    .o_stall_cycles  (o_stall_cycles),
    .o_bubble_cycles (o_bubble_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    i_valid = 1'b0; i_stall = 1'b0; i_flush = 1'b0; rst = 1'b1;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; i_valid = 1'b1; i_data = 32'hDEAD_BEEF; i_ready = 1'b1;
    tick; tick; settle;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%0h want=0", o_valid); end
    n_cmp++; if (o_data !== 32'h0) begin n_bad++; $display("FAIL rst_data got=%0h want=0", o_data); end
    n_cmp++; if (o_occupancy !== 2'd0) begin n_bad++; $display("FAIL rst_occ got=%0d want=0", o_occupancy); end
    n_cmp++; if (o_stall_cycles !== 32'd0) begin n_bad++; $display("FAIL rst_stallcnt got=%0d want=0", o_stall_cycles); end
    n_cmp++; if (o_bubble_cycles !== 32'd0) begin n_bad++; $display("FAIL rst_bubcnt got=%0d want=0", o_bubble_cycles); end
    rst = 1'b0; i_valid = 1'b0;
    settle;
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%0h want=1", o_ready); end
  endtask

  task automatic test_streaming;
    i_ready = 1'b1;
    do_reset;
    for (int i = 1; i <= 3; i++) begin
      i_valid = 1'b1; i_data = DW'(i);
      settle;
      n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL stream_ready%0d got=%0h want=1", i, o_ready); end
      n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL stream_early%0d got=%0h want=0", i, o_valid); end
      tick;
    end
    i_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      settle;
      n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid%0d got=%0h want=1", i, o_valid); end
      n_cmp++; if (o_data !== DW'(i)) begin n_bad++; $display("FAIL stream_data%0d got=%0h want=%0h", i, o_data, i); end
      tick;
    end
    settle;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drain got=%0h want=0", o_valid); end
    n_cmp++; if (o_occupancy !== 2'd0) begin n_bad++; $display("FAIL stream_occ got=%0d want=0", o_occupancy); end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] exp_q [4];
    exp_q[0] = 32'hA; exp_q[1] = 32'hB; exp_q[2] = 32'hC; exp_q[3] = 32'hD;
    i_ready = 1'b0;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; i_data = exp_q[i];
      settle;
      n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL bp_accept%0d got=%0h want=1", i, o_ready); end
      tick;
    end
    i_data = exp_q[3];
    for (int i = 0; i < 3; i++) begin
      settle;
      n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready%0d got=%0h want=0", i, o_ready); end
      n_cmp++; if (o_occupancy !== 2'd3) begin n_bad++; $display("FAIL bp_occ%0d got=%0d want=3", i, o_occupancy); end
      tick;
    end
    n_cmp++; if (o_stall_cycles !== (PERF ? 32'd3 : 32'd0)) begin n_bad++; $display("FAIL bp_stallcnt got=%0d want=%0d", o_stall_cycles, PERF ? 3 : 0); end
    // Full chain, downstream ready: pop and push in the same cycle.
    i_ready = 1'b1;
    settle;
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL bp_pushpop_ready got=%0h want=1", o_ready); end
    tick;
    i_valid = 1'b0;
    // Word A was popped on the previous edge; B, C, D follow.
    for (int i = 1; i < 4; i++) begin
      settle;
      n_cmp++; if (o_valid !== 1'b1 || o_data !== exp_q[i]) begin n_bad++; $display("FAIL bp_order%0d got=%0h/%0h want=1/%0h", i, o_valid, o_data, exp_q[i]); end
      tick;
    end
    n_cmp++; if (o_bubble_cycles !== 32'd0) begin n_bad++; $display("FAIL bp_bubcnt got=%0d want=0", o_bubble_cycles); end
  endtask

  task automatic test_flush;
    i_ready = 1'b0;
    do_reset;
    i_valid = 1'b1; i_data = 32'h11; tick;
    i_data = 32'h22; tick;
    settle;
    n_cmp++; if (o_occupancy !== 2'd2) begin n_bad++; $display("FAIL fl_occ_pre got=%0d want=2", o_occupancy); end
    i_flush = 1'b1; i_data = 32'h55;
    settle;
    n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL fl_ready got=%0h want=0", o_ready); end
    tick;
    i_flush = 1'b0; i_valid = 1'b0;
    settle;
    n_cmp++; if (o_occupancy !== 2'd0) begin n_bad++; $display("FAIL fl_occ_post got=%0d want=0", o_occupancy); end
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle;
      n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL fl_leak%0d got=%0h/%0h want=0", i, o_valid, o_data); end
      tick;
    end
  endtask

  task automatic test_stall;
    i_ready = 1'b1;
    do_reset;
    i_valid = 1'b1; i_data = 32'h31; tick;
    i_data = 32'h32; tick;
    i_stall = 1'b1; i_data = 32'h33;
    for (int i = 0; i < 5; i++) begin
      settle;
      n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b0) begin n_bad++; $display("FAIL st_hs%0d got=%0h/%0h want=0/0", i, o_valid, o_ready); end
      n_cmp++; if (o_occupancy !== 2'd2) begin n_bad++; $display("FAIL st_occ%0d got=%0d want=2", i, o_occupancy); end
      tick;
    end
    i_stall = 1'b0; i_valid = 1'b0;
    settle;
    n_cmp++; if (o_stall_cycles !== (PERF ? 32'd5 : 32'd0)) begin n_bad++; $display("FAIL st_stallcnt got=%0d want=%0d", o_stall_cycles, PERF ? 5 : 0); end
    n_cmp++; if (o_bubble_cycles !== (PERF ? 32'd2 : 32'd0)) begin n_bad++; $display("FAIL st_bubcnt got=%0d want=%0d", o_bubble_cycles, PERF ? 2 : 0); end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL st_head_gap got=%0h want=0", o_valid); end
    tick; settle;
    n_cmp++; if (o_valid !== 1'b1 || o_data !== 32'h31) begin n_bad++; $display("FAIL st_out0 got=%0h/%0h want=1/31", o_valid, o_data); end
    tick; settle;
    n_cmp++; if (o_valid !== 1'b1 || o_data !== 32'h32) begin n_bad++; $display("FAIL st_out1 got=%0h/%0h want=1/32", o_valid, o_data); end
    tick; settle;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL st_drain got=%0h/%0h want=0", o_valid, o_data); end
  endtask

  task automatic test_bubble_collapse;
    i_ready = 1'b0;
    do_reset;
    i_valid = 1'b1; i_data = 32'h7; tick;
    i_valid = 1'b0; tick; tick;
    i_valid = 1'b1; i_data = 32'h8; tick;
    i_valid = 1'b0; tick;
    settle;
    n_cmp++; if (o_occupancy !== 2'd2) begin n_bad++; $display("FAIL bc_occ got=%0d want=2", o_occupancy); end
    n_cmp++; if (o_valid !== 1'b1 || o_data !== 32'h7) begin n_bad++; $display("FAIL bc_head got=%0h/%0h want=1/7", o_valid, o_data); end
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL bc_tail_free got=%0h want=1", o_ready); end
    i_ready = 1'b1;
    tick; settle;
    n_cmp++; if (o_valid !== 1'b1 || o_data !== 32'h8) begin n_bad++; $display("FAIL bc_second got=%0h/%0h want=1/8", o_valid, o_data); end
    tick; settle;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL bc_drain got=%0h want=0", o_valid); end
  endtask

  task automatic test_reset_midstream;
    i_ready = 1'b0;
    do_reset;
    i_valid = 1'b1; i_data = 32'h41; tick;
    i_data = 32'h42; tick;
    i_valid = 1'b0; i_stall = 1'b1; i_flush = 1'b1; rst = 1'b1;
    tick;
    rst = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    settle;
    n_cmp++; if (o_occupancy !== 2'd0) begin n_bad++; $display("FAIL mr_occ got=%0d want=0", o_occupancy); end
    n_cmp++; if (o_stall_cycles !== 32'd0) begin n_bad++; $display("FAIL mr_stallcnt got=%0d want=0", o_stall_cycles); end
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL mr_ready got=%0h want=1", o_ready); end
  endtask

  initial begin
    test_reset;
    test_streaming;
    test_backpressure;
    test_flush;
    test_stall;
    test_bubble_collapse;
    test_reset_midstream;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
